// File: rtl/moesi_bus_sequencer.sv
// moesi_bus_sequencer
// Shared snoop-bus sequencer for a group of MOESI cache controllers.
// Picks one requester round-robin and broadcasts its operation to every
// controller. It then collects the shared and intervention responses and
// finishes the transaction from memory or by cache-to-cache supply.
// bus_shared and bus_from_state are returned to the master with its done
// pulse, so the master can pick its next MOESI state.
module moesi_bus_sequencer #(
  parameter int NUM_CACHES  = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_CACHES-1:0]            req_read,
  input  logic [NUM_CACHES-1:0]            req_rwitm,
  input  logic [NUM_CACHES-1:0]            req_invalidate,
  input  logic [NUM_CACHES*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CACHES-1:0]            snoop_shared,
  input  logic [NUM_CACHES-1:0]            snoop_abort,
  input  logic [3*NUM_CACHES-1:0]          snoop_state,
  output logic [NUM_CACHES-1:0]            grant,
  output logic [NUM_CACHES-1:0]            done,
  output logic [$clog2(NUM_CACHES)-1:0]    bus_master,
  output logic [ADDR_WIDTH-1:0]            bus_addr,
  output logic                             bus_read,
  output logic                             bus_rwitm,
  output logic                             bus_invalidate,
  output logic                             bus_shared,
  output logic [2:0]                       bus_from_state,
  output logic                             mem_read
);

  localparam int MW = $clog2(NUM_CACHES);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SNOOP    = 3'd1;
  localparam logic [2:0] ST_MEM_WAIT = 3'd2;
  localparam logic [2:0] ST_C2C      = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  localparam logic [2:0] FROM_NONE = 3'b000;
  localparam logic [2:0] FROM_MEM  = 3'b101;

  logic [2:0]            state;
  logic [MW-1:0]         last_grant;
  logic [3:0]            mem_count;

  logic [NUM_CACHES-1:0] pending;
  logic [NUM_CACHES-1:0] master_mask;
  logic [NUM_CACHES-1:0] winner_mask;
  logic [NUM_CACHES-1:0] masked_shared;
  logic [NUM_CACHES-1:0] masked_abort;
  logic                  found_winner;
  logic [MW-1:0]         winner;
  logic [MW-1:0]         cand;
  logic                  found_abort;
  logic [MW-1:0]         abort_idx;
  logic [2:0]            supplier_state;

  // A cache is pending as soon as any one of its three request bits is set.
  assign pending       = req_read | req_rwitm | req_invalidate;
  assign master_mask   = {{(NUM_CACHES-1){1'b0}}, 1'b1} << bus_master;
  assign winner_mask   = {{(NUM_CACHES-1){1'b0}}, 1'b1} << winner;
  // The master never snoops its own transaction, so its response bits are dropped.
  assign masked_shared = snoop_shared & ~master_mask;
  assign masked_abort  = snoop_abort & ~master_mask;
  assign supplier_state = snoop_state[3*abort_idx +: 3];

  // Round-robin search starting just after the last master and wrapping
  // modulo NUM_CACHES. This works by MW-bit overflow because NUM_CACHES is
  // a power of two.
  always_comb begin
    found_winner = 1'b0;
    winner       = '0;
    cand         = '0;
    for (int k = 1; k <= NUM_CACHES; k++) begin
      cand = last_grant + MW'(k);
      if (!found_winner && pending[cand]) begin
        found_winner = 1'b1;
        winner       = cand;
      end
    end
  end

  // The lowest-index non-master intervener supplies the data.
  always_comb begin
    found_abort = 1'b0;
    abort_idx   = '0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      if (!found_abort && masked_abort[i]) begin
        found_abort = 1'b1;
        abort_idx   = MW'(i);
      end
    end
  end

  // Transaction sequencer: arbitrate, snoop, then complete from memory or a
  // supplier cache, and finally pulse done to the master.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      last_grant     <= MW'(NUM_CACHES - 1);
      mem_count      <= '0;
      grant          <= '0;
      done           <= '0;
      bus_master     <= '0;
      bus_addr       <= '0;
      bus_read       <= 1'b0;
      bus_rwitm      <= 1'b0;
      bus_invalidate <= 1'b0;
      bus_shared     <= 1'b0;
      bus_from_state <= FROM_NONE;
      mem_read       <= 1'b0;
    end else begin
      grant <= '0;
      done  <= '0;
      case (state)
        ST_IDLE: begin
          if (found_winner) begin
            state          <= ST_SNOOP;
            grant          <= winner_mask;
            bus_master     <= winner;
            bus_addr       <= req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
            bus_rwitm      <= req_rwitm[winner];
            bus_invalidate <= !req_rwitm[winner] && req_invalidate[winner];
            bus_read       <= !req_rwitm[winner] && !req_invalidate[winner]
                              && req_read[winner];
          end
        end
        ST_SNOOP: begin
          bus_shared <= |masked_shared;
          if (bus_invalidate) begin
            state          <= ST_DONE;
            done           <= master_mask;
            bus_from_state <= FROM_NONE;
          end else if (found_abort) begin
            state          <= ST_C2C;
            bus_from_state <= supplier_state;
          end else begin
            state     <= ST_MEM_WAIT;
            mem_read  <= 1'b1;
            mem_count <= 4'(MEM_LATENCY - 1);
          end
        end
        ST_MEM_WAIT: begin
          if (mem_count == '0) begin
            state          <= ST_DONE;
            done           <= master_mask;
            bus_from_state <= FROM_MEM;
            mem_read       <= 1'b0;
          end else begin
            mem_count <= mem_count - 4'd1;
          end
        end
        ST_C2C: begin
          state <= ST_DONE;
          done  <= master_mask;
        end
        ST_DONE: begin
          state          <= ST_IDLE;
          last_grant     <= bus_master;
          bus_read       <= 1'b0;
          bus_rwitm      <= 1'b0;
          bus_invalidate <= 1'b0;
          bus_shared     <= 1'b0;
          bus_from_state <= FROM_NONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_moesi_bus_sequencer.sv
// tb_moesi_bus_sequencer
// Self-checking bench for moesi_bus_sequencer with NUM_CACHES=4,
// ADDR_WIDTH=8 and MEM_LATENCY=4. It covers hand-computed vectors,
// multi-transaction arbitration and reset sequences, and random
// transactions predicted by a transaction-level model.
module tb_moesi_bus_sequencer;

  localparam int NC  = 4;
  localparam int AW  = 8;
  localparam int LAT = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [NC-1:0]  req_read = '0;
  logic [NC-1:0]  req_rwitm = '0;
  logic [NC-1:0]  req_invalidate = '0;
  logic [NC*AW-1:0] req_addr = '0;
  logic [NC-1:0]  snoop_shared = '0;
  logic [NC-1:0]  snoop_abort = '0;
  logic [3*NC-1:0] snoop_state = '0;
  logic [NC-1:0]  grant;
  logic [NC-1:0]  done;
  logic [1:0]     bus_master;
  logic [AW-1:0]  bus_addr;
  logic           bus_read;
  logic           bus_rwitm;
  logic           bus_invalidate;
  logic           bus_shared;
  logic [2:0]     bus_from_state;
  logic           mem_read;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  rw;
    logic [3:0]  inv;
    logic [7:0]  addr;
    logic [3:0]  sh;
    logic [3:0]  ab;
    logic [11:0] st;
    logic [3:0]  eg;
    logic [2:0]  eop;
    logic [7:0]  eaddr;
    int          elat;
    logic [2:0]  efrom;
    logic        esh;
    int          emem;
  } vec_t;

  vec_t tbl[8];

  moesi_bus_sequencer #(
    .NUM_CACHES(NC),
    .ADDR_WIDTH(AW),
    .MEM_LATENCY(LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_read(req_read),
    .req_rwitm(req_rwitm),
    .req_invalidate(req_invalidate),
    .req_addr(req_addr),
    .snoop_shared(snoop_shared),
    .snoop_abort(snoop_abort),
    .snoop_state(snoop_state),
    .grant(grant),
    .done(done),
    .bus_master(bus_master),
    .bus_addr(bus_addr),
    .bus_read(bus_read),
    .bus_rwitm(bus_rwitm),
    .bus_invalidate(bus_invalidate),
    .bus_shared(bus_shared),
    .bus_from_state(bus_from_state),
    .mem_read(mem_read)
  );

  // Free-running 10 ns clock.
  always #5 clock = ~clock;

  // Hard stop in case a wait somewhere never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] rd, input logic [3:0] rw,
                               input logic [3:0] inv, input logic [31:0] addrs,
                               input logic [3:0] sh, input logic [3:0] ab,
                               input logic [11:0] st);
    req_read       = rd;
    req_rwitm      = rw;
    req_invalidate = inv;
    req_addr       = addrs;
    snoop_shared   = sh;
    snoop_abort    = ab;
    snoop_state    = st;
  endtask

  // Follows one transaction from grant to the idle cycle after done.
  // Called at a negedge while the DUT is idle, with requests already driven.
  // Returns at the negedge of the idle cycle that follows done.
  task automatic observeTxn(input string tag, input logic [3:0] eg,
                            input logic [2:0] eop, input logic [7:0] ea,
                            input int elat, input logic [2:0] efrom,
                            input logic esh, input int emem);
    int gw;
    int lat;
    int mc;
    logic [1:0] em;
    em = '0;
    for (int i = 0; i < NC; i++) if (eg[i]) em = 2'(i);
    gw = 0;
    do begin
      @(negedge clock);
      gw++;
    end while (grant == '0 && gw < 8);
    checkOutput({tag, "_gwait"}, gw, 1);
    if (grant == '0) begin
      req_read = '0; req_rwitm = '0; req_invalidate = '0;
      return;
    end
    checkOutput({tag, "_grant"}, grant, eg);
    checkOutput({tag, "_master"}, bus_master, em);
    checkOutput({tag, "_op"}, {bus_rwitm, bus_invalidate, bus_read}, eop);
    checkOutput({tag, "_addr"}, bus_addr, ea);
    lat = 0;
    mc  = 0;
    do begin
      @(negedge clock);
      lat++;
      if (mem_read) mc++;
    end while (done == '0 && lat < 40);
    checkOutput({tag, "_done"}, done, eg);
    checkOutput({tag, "_lat"}, lat, elat);
    checkOutput({tag, "_from"}, bus_from_state, efrom);
    checkOutput({tag, "_shared"}, bus_shared, esh);
    checkOutput({tag, "_op_at_done"}, {bus_rwitm, bus_invalidate, bus_read}, eop);
    checkOutput({tag, "_memcycles"}, mc, emem);
    req_read       = req_read & ~eg;
    req_rwitm      = req_rwitm & ~eg;
    req_invalidate = req_invalidate & ~eg;
    @(negedge clock);
    checkOutput({tag, "_idle_clear"},
                {grant, done, bus_read, bus_rwitm, bus_invalidate, bus_shared,
                 bus_from_state, mem_read}, 0);
    checkOutput({tag, "_idle_hold"}, {bus_master, bus_addr}, {em, ea});
  endtask

  // Round-robin choice: first pending cache after the previous master.
  function automatic int rrPick(input logic [3:0] pend, input int last);
    for (int k = 1; k <= NC; k++) begin
      if (pend[(last + k) % NC]) return (last + k) % NC;
    end
    return 0;
  endfunction

  // Main test sequence.
  initial begin
    logic [3:0]  rd, rw, inv, sh, ab, mab, msh;
    logic [31:0] ad;
    logic [11:0] st;
    logic [2:0]  eop, efrom;
    int          w, j, elat, emem, model_last, gw;

    // rd rw inv addr sh ab st | eg eop eaddr lat from shared mem
    tbl[0] = '{4'b0001, 4'b0000, 4'b0000, 8'h2A, 4'b0000, 4'b0000, 12'h000,
               4'b0001, 3'b001, 8'h2A, 5, 3'b101, 1'b0, 4};
    tbl[1] = '{4'b0000, 4'b0010, 4'b0000, 8'h10, 4'b1000, 4'b1000, 12'h200,
               4'b0010, 3'b100, 8'h11, 2, 3'b001, 1'b1, 0};
    tbl[2] = '{4'b0000, 4'b0000, 4'b0100, 8'h40, 4'b0000, 4'b0001, 12'h003,
               4'b0100, 3'b010, 8'h42, 1, 3'b000, 1'b0, 0};
    tbl[3] = '{4'b0010, 4'b0000, 4'b0000, 8'h50, 4'b0010, 4'b0010, 12'h008,
               4'b0010, 3'b001, 8'h51, 5, 3'b101, 1'b0, 4};
    tbl[4] = '{4'b1001, 4'b1000, 4'b1000, 8'h60, 4'b0100, 4'b0101, 12'h103,
               4'b1000, 3'b100, 8'h63, 2, 3'b011, 1'b1, 0};
    tbl[5] = '{4'b0100, 4'b0000, 4'b0100, 8'h70, 4'b0001, 4'b0000, 12'h000,
               4'b0100, 3'b010, 8'h72, 1, 3'b000, 1'b1, 0};
    tbl[6] = '{4'b1001, 4'b0000, 4'b0000, 8'h80, 4'b0000, 4'b0000, 12'h000,
               4'b1000, 3'b001, 8'h83, 5, 3'b101, 1'b0, 4};
    tbl[7] = '{4'b0000, 4'b0001, 4'b0000, 8'h90, 4'b0001, 4'b0101, 12'h043,
               4'b0001, 3'b100, 8'h90, 2, 3'b001, 1'b0, 0};

    repeat (3) @(negedge clock);
    checkOutput("reset_outputs",
                {grant, done, bus_master, bus_addr, bus_read, bus_rwitm,
                 bus_invalidate, bus_shared, bus_from_state, mem_read}, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].rd, tbl[i].rw, tbl[i].inv,
                    {tbl[i].addr + 8'd3, tbl[i].addr + 8'd2,
                     tbl[i].addr + 8'd1, tbl[i].addr},
                    tbl[i].sh, tbl[i].ab, tbl[i].st);
      observeTxn($sformatf("vec%0d", i), tbl[i].eg, tbl[i].eop, tbl[i].eaddr,
                 tbl[i].elat, tbl[i].efrom, tbl[i].esh, tbl[i].emem);
    end

    // Simultaneous readers 0,1,3 then cache 0 re-requests while 3 pends.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(4'b1011, 4'b0000, 4'b0000, 32'h33221100, 4'b0000, 4'b0000, 12'h000);
    observeTxn("rr_first", 4'b0001, 3'b001, 8'h00, 5, 3'b101, 1'b0, 4);
    observeTxn("rr_second", 4'b0010, 3'b001, 8'h11, 5, 3'b101, 1'b0, 4);
    req_read[0] = 1'b1;
    observeTxn("rr_wrap3", 4'b1000, 3'b001, 8'h33, 5, 3'b101, 1'b0, 4);
    observeTxn("rr_wrap0", 4'b0001, 3'b001, 8'h00, 5, 3'b101, 1'b0, 4);

    // Reset in the middle of a memory wait.
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 32'h33221100, 4'b0000, 4'b0000, 12'h000);
    gw = 0;
    do begin
      @(negedge clock);
      gw++;
    end while (grant == '0 && gw < 8);
    checkOutput("midrst_grant", grant, 4'b0100);
    repeat (2) @(negedge clock);
    checkOutput("midrst_memread", mem_read, 1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midrst_outputs",
                {grant, done, bus_master, bus_addr, bus_read, bus_rwitm,
                 bus_invalidate, bus_shared, bus_from_state, mem_read}, 0);
    reset = 1'b0;
    applyStimulus(4'b0101, 4'b0000, 4'b0000, 32'h33221100, 4'b0000, 4'b0000, 12'h000);
    observeTxn("postrst", 4'b0001, 3'b001, 8'h00, 5, 3'b101, 1'b0, 4);
    model_last = 0;

    // Random transactions against the transaction-level model.
    for (int n = 0; n < 30; n++) begin
      rd  = 4'($urandom);
      rw  = 4'($urandom) & 4'($urandom);
      inv = 4'($urandom) & 4'($urandom);
      if ((rd | rw | inv) == 4'b0) rd[$urandom_range(0, 3)] = 1'b1;
      ad  = $urandom;
      sh  = 4'($urandom);
      ab  = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      st  = 12'($urandom);
      w   = rrPick(rd | rw | inv, model_last);
      eop = rw[w] ? 3'b100 : (inv[w] ? 3'b010 : 3'b001);
      mab = ab & ~(4'b0001 << w);
      msh = sh & ~(4'b0001 << w);
      if (eop == 3'b010) begin
        elat = 1; efrom = 3'b000; emem = 0;
      end else if (mab != 4'b0000) begin
        j = 0;
        while (!mab[j]) j++;
        elat = 2; efrom = st[3*j +: 3]; emem = 0;
      end else begin
        elat = LAT + 1; efrom = 3'b101; emem = LAT;
      end
      applyStimulus(rd, rw, inv, ad, sh, ab, st);
      observeTxn($sformatf("rnd%0d", n), 4'(4'b0001 << w), eop, ad[8*w +: 8],
                 elat, efrom, |msh, emem);
      model_last = w;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
